// File: rtl/lockstep_compare_harness_if.sv
// Handshake/bus bundle between the lockstep harness and its environment.
// master: harness side (drives stimulus/status); slave: DUT pair + controller.
interface lockstep_compare_harness_if #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [DATA_W-1:0] stim;
    logic              dut_rst;
    logic [OUT_W-1:0]  golden_out;
    logic [OUT_W-1:0]  netlist_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [31:0]       vec_idx;
`ifdef HARNESS_FIRST_FAIL_EN
    logic [31:0]       first_fail_idx;
    logic [OUT_W-1:0]  first_fail_golden;
    logic [OUT_W-1:0]  first_fail_netlist;
    logic              first_fail_vld;

    modport master (
        input  start, golden_out, netlist_out,
        output stim, dut_rst, busy, done, pass, mismatch_cnt, vec_idx,
        output first_fail_idx, first_fail_golden,
        output first_fail_netlist, first_fail_vld
    );
    modport slave (
        output start, golden_out, netlist_out,
        input  stim, dut_rst, busy, done, pass, mismatch_cnt, vec_idx,
        input  first_fail_idx, first_fail_golden,
        input  first_fail_netlist, first_fail_vld
    );
`else
    modport master (
        input  start, golden_out, netlist_out,
        output stim, dut_rst, busy, done, pass, mismatch_cnt, vec_idx
    );
    modport slave (
        output start, golden_out, netlist_out,
        input  stim, dut_rst, busy, done, pass, mismatch_cnt, vec_idx
    );
`endif
endinterface

// File: rtl/lockstep_compare_harness.sv
// Golden-vs-netlist lockstep harness: resets both DUTs, drives LFSR stimulus,
// compares outputs once per vector and reports a saturating mismatch count.
// Ports: clk, rst (async, active high), bus (master modport: start,
// golden_out, netlist_out in; stim, dut_rst, busy, done, pass,
// mismatch_cnt, vec_idx out). Optional first-fail capture ports are
// enabled by defining HARNESS_FIRST_FAIL_EN.
module lockstep_compare_harness #(
    parameter int          DATA_W       = 32,
    parameter int          OUT_W        = 32,
    parameter int          N_VECTORS    = 1000,
    parameter int          COMPARE_LAT  = 2,
    parameter int          RESET_CYCLES = 2,
    parameter logic [31:0] SEED         = 32'h0000_0001,
    parameter int          CNT_W        = 16
) (
    input logic                        clk,
    input logic                        rst,
    lockstep_compare_harness_if.master bus
);
    localparam logic [31:0] POLY    = 32'h8020_0003;
    localparam logic [31:0] SEED_EF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] RC_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] CL_LAST = 32'(COMPARE_LAT - 1);
    localparam logic [31:0] V_LAST  = 32'(N_VECTORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE, ST_RESET, ST_RUN, ST_DONE
    } state_t;

    state_t            state;
    logic [31:0]       cyc;
    logic [31:0]       lfsr;
    logic [DATA_W-1:0] stim_q;
    logic              dut_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       vec_idx_q;

    logic [31:0]       lfsr_nxt;
    logic              mismatch;
    logic              cmp;
    logic [CNT_W-1:0]  cnt_nxt;

    assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'd0);
    assign mismatch = bus.golden_out != bus.netlist_out;
    assign cmp = (state == ST_RESET && cyc == RC_LAST) ||
                 (state == ST_RUN && cyc == CL_LAST);
    // Count including the compare taken this edge, so DONE's pass sees it.
    assign cnt_nxt = (cmp && mismatch && cnt_q != '1) ? cnt_q + 1'b1
                                                      : cnt_q;

`ifdef HARNESS_FIRST_FAIL_EN
    logic [31:0]      ff_idx;
    logic [OUT_W-1:0] ff_gold;
    logic [OUT_W-1:0] ff_net;
    logic             ff_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_idx  <= '0;
            ff_gold <= '0;
            ff_net  <= '0;
            ff_vld  <= 1'b0;
        end else if ((state == ST_IDLE || state == ST_DONE) && bus.start) begin
            ff_idx  <= '0;
            ff_gold <= '0;
            ff_net  <= '0;
            ff_vld  <= 1'b0;
        end else if (cmp && mismatch && !ff_vld) begin
            // The reset-state compare has no vector index of its own.
            ff_idx  <= (state == ST_RESET) ? 32'hFFFF_FFFF : vec_idx_q;
            ff_gold <= bus.golden_out;
            ff_net  <= bus.netlist_out;
            ff_vld  <= 1'b1;
        end
    end

    assign bus.first_fail_idx     = ff_idx;
    assign bus.first_fail_golden  = ff_gold;
    assign bus.first_fail_netlist = ff_net;
    assign bus.first_fail_vld     = ff_vld;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cyc       <= '0;
            lfsr      <= SEED_EF;
            stim_q    <= '0;
            dut_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cnt_q     <= '0;
            vec_idx_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state     <= ST_RESET;
                        cyc       <= '0;
                        lfsr      <= SEED_EF;
                        stim_q    <= '0;
                        dut_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        cnt_q     <= '0;
                        vec_idx_q <= '0;
                    end
                end
                ST_RESET: begin
                    if (cyc == RC_LAST) begin
                        cnt_q     <= cnt_nxt;
                        state     <= ST_RUN;
                        cyc       <= '0;
                        dut_rst_q <= 1'b0;
                        stim_q    <= lfsr[DATA_W-1:0];
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cyc == CL_LAST) begin
                        cnt_q <= cnt_nxt;
                        cyc   <= '0;
                        if (vec_idx_q == V_LAST) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (cnt_nxt == '0);
                        end else begin
                            vec_idx_q <= vec_idx_q + 1'b1;
                            lfsr      <= lfsr_nxt;
                            stim_q    <= lfsr_nxt[DATA_W-1:0];
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.stim         = stim_q;
    assign bus.dut_rst      = dut_rst_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = cnt_q;
    assign bus.vec_idx      = vec_idx_q;
endmodule

// File: tb/tb_lockstep_compare_harness.sv
// Scoreboard bench for lockstep_compare_harness: three harness instances
// (defaults, parameter corner, saturation) with behavioural DUT pairs.
module tb_lockstep_compare_harness;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    lockstep_compare_harness_if #(.DATA_W(32), .OUT_W(32), .CNT_W(16)) ia();
    lockstep_compare_harness_if #(.DATA_W(8),  .OUT_W(32), .CNT_W(16)) ib();
    lockstep_compare_harness_if #(.DATA_W(32), .OUT_W(32), .CNT_W(4))  ic();

    lockstep_compare_harness ua (.clk(clk), .rst(rst), .bus(ia));
    lockstep_compare_harness #(
        .DATA_W(8), .COMPARE_LAT(1), .RESET_CYCLES(1), .N_VECTORS(1)
    ) ub (.clk(clk), .rst(rst), .bus(ib));
    lockstep_compare_harness #(
        .CNT_W(4), .N_VECTORS(40)
    ) uc (.clk(clk), .rst(rst), .bus(ic));

    // Behavioural DUT pairs: one-cycle register of stim, cleared by dut_rst.
    logic [31:0] ra, rc;
    logic [7:0]  rb;
    int amode = 0;
    always @(posedge clk) begin
        ra <= ia.dut_rst ? 32'd0 : ia.stim;
        rb <= ib.dut_rst ? 8'd0  : ib.stim;
        rc <= ic.dut_rst ? 32'd0 : ic.stim;
    end
    assign ia.golden_out  = (amode == 2 && ia.dut_rst) ? 32'd1 : ra;
    assign ia.netlist_out = ra ^ ((amode == 1 && ia.vec_idx == 32'd5)
                                  ? 32'd1 : 32'd0);
    assign ib.golden_out  = {24'd0, rb};
    assign ib.netlist_out = {24'd0, rb};
    assign ic.golden_out  = rc;
    assign ic.netlist_out = 32'd0;

    localparam int S_PASS = 0, S_CNT = 1, S_DONE = 2, S_V0 = 3, S_V1 = 4;
    localparam int S_STIM = 5, S_FFI = 6, S_FFV = 7, S_FFG = 8, S_FFN = 9;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t q[3][$];
    int done_edge[3];
    logic [31:0] v0, v1;
    int passed = 0;
    int total = 0;

    function automatic void check(string n, logic [63:0] act,
                                  logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    endfunction

    function automatic logic done_of(int i);
        case (i)
            0: return ia.done;
            1: return ib.done;
            default: return ic.done;
        endcase
    endfunction

    function automatic logic [63:0] obs(int i, int sel);
        logic [63:0] r;
        r = '0;
        case (sel)
            S_PASS: r = {63'd0, i == 0 ? ia.pass : i == 1 ? ib.pass : ic.pass};
            S_CNT:  r = i == 0 ? 64'(ia.mismatch_cnt) :
                        i == 1 ? 64'(ib.mismatch_cnt) : 64'(ic.mismatch_cnt);
            S_DONE: r = 64'(done_edge[i]);
            S_V0:   r = 64'(v0);
            S_V1:   r = 64'(v1);
            S_STIM: r = i == 0 ? 64'(ia.stim) :
                        i == 1 ? 64'(ib.stim) : 64'(ic.stim);
`ifdef HARNESS_FIRST_FAIL_EN
            S_FFI:  r = 64'(ia.first_fail_idx);
            S_FFV:  r = 64'(ia.first_fail_vld);
            S_FFG:  r = 64'(ia.first_fail_golden);
            S_FFN:  r = 64'(ia.first_fail_netlist);
`endif
            default: r = '1;
        endcase
        return r;
    endfunction

    task automatic expect_at_done(int i, string n, int sel, logic [63:0] e);
        exp_t x;
        x.name = n;
        x.sel  = sel;
        x.exp  = e;
        q[i].push_back(x);
    endtask

    // Monitor: snapshots early vectors, drains the scoreboard on done rise.
    initial begin
        logic [2:0] dprev;
        exp_t x;
        dprev = '0;
        forever begin
            @(negedge clk);
            if (ia.busy && !ia.dut_rst && ia.vec_idx == 32'd0) v0 = ia.stim;
            if (ia.busy && !ia.dut_rst && ia.vec_idx == 32'd1) v1 = ia.stim;
            for (int i = 0; i < 3; i++) begin
                if (done_of(i) && !dprev[i]) begin
                    done_edge[i] = cyc + 1;
                    while (q[i].size() > 0) begin
                        x = q[i].pop_front();
                        check(x.name, obs(i, x.sel), x.exp);
                    end
                end
                dprev[i] = done_of(i);
            end
        end
    end

    function automatic logic [31:0] lfsr_vec(int k);
        logic [31:0] l;
        l = 32'd1;
        for (int j = 0; j < k; j++)
            l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'd0);
        return l;
    endfunction

    task automatic set_start(int i, logic v);
        case (i)
            0: ia.start = v;
            1: ib.start = v;
            default: ic.start = v;
        endcase
    endtask

    task automatic launch(int i, int lat);
        @(negedge clk);
        expect_at_done(i, "done_time", S_DONE, 64'(cyc + 1 + lat));
        set_start(i, 1'b1);
        @(negedge clk);
        set_start(i, 1'b0);
    endtask

    task automatic wait_done(int i, int lim, string n);
        for (int k = 0; k < lim; k++) begin
            if (done_of(i)) break;
            @(negedge clk);
        end
        if (!done_of(i)) check(n, 64'(done_of(i)), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_state_checks(string tag);
        check({tag, "_stim"},    64'(ia.stim), 64'd0);
        check({tag, "_dut_rst"}, 64'(ia.dut_rst), 64'd1);
        check({tag, "_busy"},    64'(ia.busy), 64'd0);
        check({tag, "_done"},    64'(ia.done), 64'd0);
        check({tag, "_pass"},    64'(ia.pass), 64'd0);
        check({tag, "_cnt"},     64'(ia.mismatch_cnt), 64'd0);
        check({tag, "_vec_idx"}, 64'(ia.vec_idx), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v5;
        logic        hit;
        rst = 1'b1;
        ia.start = 1'b0;
        ib.start = 1'b0;
        ic.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        reset_state_checks("por");

        expect_at_done(0, "ident_pass", S_PASS, 64'd1);
        expect_at_done(0, "ident_cnt",  S_CNT,  64'd0);
        expect_at_done(0, "ident_v0",   S_V0,   64'h0000_0001);
        expect_at_done(0, "ident_v1",   S_V1,   64'h8020_0003);
        launch(0, 2003);
        wait_done(0, 2100, "ident_timeout");

        v5 = lfsr_vec(5);
        amode = 1;
        expect_at_done(0, "fault_pass", S_PASS, 64'd0);
        expect_at_done(0, "fault_cnt",  S_CNT,  64'd1);
`ifdef HARNESS_FIRST_FAIL_EN
        expect_at_done(0, "fault_ff_idx", S_FFI, 64'd5);
        expect_at_done(0, "fault_ff_vld", S_FFV, 64'd1);
        expect_at_done(0, "fault_ff_gold", S_FFG, 64'(v5));
        expect_at_done(0, "fault_ff_net", S_FFN, 64'(v5 ^ 32'd1));
`endif
        launch(0, 2003);
        wait_done(0, 2100, "fault_timeout");

        amode = 2;
        expect_at_done(0, "rstcmp_pass", S_PASS, 64'd0);
        expect_at_done(0, "rstcmp_cnt",  S_CNT,  64'd1);
`ifdef HARNESS_FIRST_FAIL_EN
        expect_at_done(0, "rstcmp_ff_idx", S_FFI, 64'hFFFF_FFFF);
`endif
        launch(0, 2003);
        check("restart_cnt_clear", 64'(ia.mismatch_cnt), 64'd0);
        check("restart_done_low",  64'(ia.done), 64'd0);
        check("restart_busy",      64'(ia.busy), 64'd1);
        wait_done(0, 2100, "rstcmp_timeout");

        expect_at_done(1, "corner_pass", S_PASS, 64'd1);
        expect_at_done(1, "corner_stim", S_STIM, 64'h01);
        expect_at_done(1, "corner_cnt",  S_CNT,  64'd0);
        @(negedge clk);
        expect_at_done(1, "corner_done_time", S_DONE, 64'(cyc + 1 + 3));
        ib.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ib.start = 1'b0;
        wait_done(1, 20, "corner_timeout");
        repeat (3) @(negedge clk);
        check("corner_extra_start_ignored", 64'(ib.busy), 64'd0);
        check("corner_done_held", 64'(ib.done), 64'd1);

        expect_at_done(2, "sat_cnt",  S_CNT,  64'd15);
        expect_at_done(2, "sat_pass", S_PASS, 64'd0);
        launch(2, 83);
        wait_done(2, 200, "sat_timeout");

        amode = 0;
        @(negedge clk);
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (ia.vec_idx == 32'd300) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reach_vec300", 64'(hit), 64'd1);
        #2 rst = 1'b1;
        #1 reset_state_checks("async");
`ifdef HARNESS_FIRST_FAIL_EN
        check("async_ff_vld", 64'(ia.first_fail_vld), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_done", 64'(ia.done), 64'd0);

        expect_at_done(0, "clean_pass", S_PASS, 64'd1);
        expect_at_done(0, "clean_cnt",  S_CNT,  64'd0);
        launch(0, 2003);
        wait_done(0, 2100, "clean_timeout");

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("sb_drained_%0d", i), 64'(q[i].size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lockstep_compare_harness.md
# lockstep_compare_harness

Synthesizable, parametrised successor to the post-route golden-vs-netlist simulation bench. It generates a reset sequence and pseudo-random stimulus and drives them into two instances of the same design, the RTL golden model and the post-route netlist. It samples both outputs after a configurable latency, counts mismatches and reports pass/fail. It sits at the top of the per-design emulation wrapper, so equivalence checks run on FPGA or in a fast cycle-based sim without `$random` or `$display`.

## Interface
- `DATA_W`, 32: stimulus width, 1..32.
- `OUT_W`, 32: width of the compared DUT outputs.
- `N_VECTORS`, 1000: random vectors per run, ≥1.
- `COMPARE_LAT`, 2: cycles each vector is held; compare on the last, ≥1.
- `RESET_CYCLES`, 2: cycles the DUT reset is held, ≥1.
- `SEED`, 32'h0000_0001: LFSR seed; a value of 0 is replaced by 1.
- `CNT_W`, 16: mismatch counter width.
- `clk` in 1: single clock. All DUTs run on it.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run. Sampled in IDLE or DONE only.
- `stim` out DATA_W: stimulus to both DUTs.
- `dut_rst` out 1: reset to both DUTs.
- `golden_out` in OUT_W: golden model output.
- `netlist_out` in OUT_W: post-route netlist output.
- `busy` out 1: run in progress.
- `done` out 1: run finished. Held until the next `start` or `rst`.
- `pass` out 1: valid when `done`. High when `mismatch_cnt == 0`.
- `mismatch_cnt` out CNT_W: saturating count of failed compares.
- `vec_idx` out 32: index of the vector currently applied.

## Operation
- FSM states: IDLE → RESET → RUN → DONE. From DONE, `start` → RESET.
- **IDLE**
  - `stim`=0, `dut_rst`=1, `busy`=0, `done`=0.
- **RESET**
  - `dut_rst`=1 and `stim`=0 for RESET_CYCLES cycles.
  - One compare is taken at the last RESET cycle (the reset-state check).
  - `mismatch_cnt`, `vec_idx` and the LFSR are cleared or reloaded on entry.
- **RUN**
  - `dut_rst`=0.
  - Vector k is held for COMPARE_LAT cycles, and one compare is taken at the edge ending its last cycle.
  - After that compare, `vec_idx` increments and the LFSR advances one step.
  - After vector N_VECTORS−1 is compared, the FSM enters DONE.
- **DONE**
  - `busy`=0, `done`=1, `stim` holds its last value, `dut_rst`=0.
- **LFSR**
  - 32-bit Galois, shifts right, polynomial mask 32'h8020_0003.
  - Vector 0 is SEED. `stim` is the LFSR's `[DATA_W-1:0]` bits.
- **Compare**
  - Full OUT_W equality test of `golden_out` against `netlist_out`.
  - On inequality, `mismatch_cnt` increments, saturating at 2^CNT_W−1.
- Compares per run = N_VECTORS+1.
- `start` while `busy` is ignored.

## Timing
- Reset values: `stim`=0, `dut_rst`=1, `busy`=0, `done`=0, `pass`=0, `mismatch_cnt`=0, `vec_idx`=0, FSM=IDLE.
- `rst` asserted mid-run forces all reset values immediately (asynchronously). The run is abandoned, with no partial `done`.
- `start` high at edge t0 in IDLE gives:
  - `busy`=1 and `dut_rst`=1 from t0+1.
  - RUN from t0+1+RESET_CYCLES.
  - `done`=1 from t0+1+RESET_CYCLES+N_VECTORS·COMPARE_LAT.
- `pass` is registered at DONE entry and already includes the final compare.
- `mismatch_cnt` updates one cycle after its compare edge.
- Restart from DONE clears the counters in the first RESET cycle.

## Configuration
- `HARNESS_FIRST_FAIL_EN` defined:
  - Adds outputs `first_fail_idx` (32), `first_fail_golden` (OUT_W), `first_fail_netlist` (OUT_W) and `first_fail_vld` (1).
  - These capture the first mismatching compare of a run.
  - The RESET-phase compare is reported as index 32'hFFFF_FFFF.
  - All four are cleared by `rst` and on RESET entry.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan
- **Identical DUTs.** Golden = netlist = one-cycle register of `stim`, defaults, pulse `start` → `done` 2003 cycles later, `pass`=1, `mismatch_cnt`=0, vector0 `stim`=32'h0000_0001, vector1 `stim`=32'h8020_0003.
- **Single injected fault.** Netlist output XORed with 1 only while `vec_idx`==5 → `mismatch_cnt`=1, `pass`=0. With `HARNESS_FIRST_FAIL_EN` also `first_fail_idx`=5, `first_fail_vld`=1.
- **Saturation.** Netlist output tied to 0, golden = registered `stim`, CNT_W=4, N_VECTORS=40 → `mismatch_cnt`=15 at `done`, `pass`=0.
- **Reset-state compare.** Golden outputs 1 while `dut_rst`, netlist outputs 0 → `mismatch_cnt`≥1. With `HARNESS_FIRST_FAIL_EN`, `first_fail_idx`=32'hFFFF_FFFF.
- **Async reset mid-run.** Assert `rst` between edges at vector 300 → outputs reach reset values before the next edge, FSM in IDLE, next `start` gives a full clean run with `pass`=1.
- **Parameter corners.** DATA_W=8, COMPARE_LAT=1, RESET_CYCLES=1, N_VECTORS=1, `start` asserted while `busy` → `done` 3 cycles after `start`, `stim`=8'h01, extra `start` ignored.
